// File: rtl/data_mem_controller_if.sv
// rtl/data_mem_controller_if.sv - word-addressed, byte-enabled data memory bus
// The controller is the master; the memory (or bench) is the slave.
interface data_mem_controller_if #(
  parameter int ADDR_W = 30
);
  logic [ADDR_W-1:0] DataMem_Address;
  logic [31:0]       DataMem_Out;
  logic [3:0]        DataMem_WE;
  logic              DataMem_Read;
  logic [31:0]       DataMem_In;
  logic              DataMem_Ready;

  modport master (
    output DataMem_Address,
    output DataMem_Out,
    output DataMem_WE,
    output DataMem_Read,
    input  DataMem_In,
    input  DataMem_Ready
  );

  modport slave (
    input  DataMem_Address,
    input  DataMem_Out,
    input  DataMem_WE,
    input  DataMem_Read,
    output DataMem_In,
    output DataMem_Ready
  );
endinterface

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - MEM-stage load/store/LL/SC controller
// Big-endian lanes; results held across external stalls so an access is never re-issued.
module data_mem_controller #(
  parameter int ADDR_W = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W+1:0]     Address,
  input  logic [31:0]           DataIn,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  SignExtend,
  input  logic                  LLSC,
  input  logic                  Eret,
  input  logic                  M_Kill,
  input  logic                  M_Stall,
  output logic [31:0]           DataOut,
  output logic                  M_Stall_Controller,
  output logic                  EXC_AdEL,
  output logic                  EXC_AdES,
  data_mem_controller_if.master dmem
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_done;
  logic [31:0]       r_hold;
  logic              r_atomic;
  logic [ADDR_W-1:0] r_res_addr;

  logic [ADDR_W-1:0] w_word_addr;
  logic [1:0]        w_off;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_misaligned;
  logic              w_ll;
  logic              w_sc;
  logic              w_res_match;
  logic              w_sc_fail;
  logic              w_start;
  logic              w_active;
  logic              w_go;
  logic              w_complete;
  logic [3:0]        w_we_mask;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_result;

  assign w_word_addr  = Address[ADDR_W+1:2];
  assign w_off        = Address[1:0];
  assign w_is_byte    = (Size == 2'b00);
  assign w_is_half    = (Size == 2'b01);
  assign w_is_word    = Size[1];
  assign w_misaligned = (w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00));

  assign EXC_AdEL = MemRead  & w_misaligned;
  assign EXC_AdES = MemWrite & w_misaligned;

  assign w_ll        = MemRead & LLSC;
  assign w_sc        = MemWrite & LLSC;
  assign w_res_match = r_atomic & (r_res_addr == w_word_addr);
  // SC is judged only at its start; once BUSY the write must run to completion.
  assign w_sc_fail   = w_sc & ~w_res_match & (r_state == IDLE);

  assign w_start    = (MemRead | MemWrite) & ~w_misaligned & ~M_Kill & ~r_done & (r_state == IDLE);
  assign w_active   = reset & (w_start | (r_state == BUSY));
  assign w_go       = w_active & ~w_sc_fail;
  assign w_complete = w_go & dmem.DataMem_Ready;

  always_comb begin
    w_we_mask = 4'b1111;
    if (w_is_byte) begin
      w_we_mask = 4'b1000 >> w_off;
    end else if (w_is_half) begin
      w_we_mask = w_off[1] ? 4'b0011 : 4'b1100;
    end
  end

  assign dmem.DataMem_Address = w_word_addr;
  assign dmem.DataMem_Out     = w_is_byte ? {4{DataIn[7:0]}} :
                                w_is_half ? {2{DataIn[15:0]}} : DataIn;

  // Byte at offset k lives in lane 3-k, i.e. shifted down by 8*(3-k).
  assign w_byte = 8'(dmem.DataMem_In >> {~w_off, 3'b000});
  assign w_half = w_off[1] ? dmem.DataMem_In[15:0] : dmem.DataMem_In[31:16];

  always_comb begin
    w_load = dmem.DataMem_In;
    if (w_is_byte) begin
      w_load = {{24{SignExtend & w_byte[7]}}, w_byte};
    end else if (w_is_half) begin
      w_load = {{16{SignExtend & w_half[15]}}, w_half};
    end
  end

  assign w_result = w_sc ? 32'd1 : (MemRead ? w_load : 32'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    dmem.DataMem_Read  = 1'b0;
    dmem.DataMem_WE    = 4'b0000;
    M_Stall_Controller = 1'b0;
    DataOut            = 32'd0;

    case (r_state)
      IDLE:    if (w_go && !dmem.DataMem_Ready) w_state_next = BUSY;
      BUSY:    if (dmem.DataMem_Ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    if (w_go) begin
      dmem.DataMem_Read  = MemRead;
      dmem.DataMem_WE    = MemWrite ? w_we_mask : 4'b0000;
      M_Stall_Controller = ~dmem.DataMem_Ready;
    end

    if (r_done) begin
      DataOut = r_hold;
    end else if (w_complete) begin
      DataOut = w_result;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_done     <= 1'b0;
      r_hold     <= 32'd0;
      r_atomic   <= 1'b0;
      r_res_addr <= '0;
    end else begin
      if (r_done && !M_Stall) begin
        r_done <= 1'b0;
      end else if (w_complete && M_Stall) begin
        r_done <= 1'b1;
        r_hold <= w_result;
      end

      // Eret has priority over a coinciding LL completion.
      if (Eret) begin
        r_atomic <= 1'b0;
      end else if (w_complete && w_ll) begin
        r_atomic   <= 1'b1;
        r_res_addr <= w_word_addr;
      end else if (w_complete && w_sc) begin
        r_atomic <= 1'b0;
      end else if (w_complete && MemWrite && (r_res_addr == w_word_addr)) begin
        r_atomic <= 1'b0;
      end
    end
  end

endmodule
